// File: rtl/diff_demo_pkg.sv
// Shared types for the convolution PE and its sequencing controller.
//   PE_state_t        : PE step index, PE_IDLE (0) when the PE is not computing
//   PE_weight_mode_t  : kernel phase selecting the PE multiplexer routing
//   ctrl_state_t      : controller FSM states of pe_seq_ctrl
//   STEPS_3X3/5X5     : activation steps per phase for each kernel size
//   PHASE_ORDER       : phase order of a 5x5 tile
package diff_demo_pkg;

    typedef logic [2:0] PE_state_t;
    localparam PE_state_t PE_IDLE = 3'd0;

    typedef enum logic [2:0] {
        E_MODE = 3'd0,
        A_MODE = 3'd1,
        B_MODE = 3'd2,
        C_MODE = 3'd3,
        D_MODE = 3'd4
    } PE_weight_mode_t;

    typedef enum logic [2:0] {
        CTRL_IDLE    = 3'd0,
        CTRL_REQ_W   = 3'd1,
        CTRL_SETTLE  = 3'd2,
        CTRL_COMPUTE = 3'd3,
        CTRL_FIN     = 3'd4,
        CTRL_DONE    = 3'd5
    } ctrl_state_t;

    localparam PE_state_t STEPS_3X3 = 3'd3;
    localparam PE_state_t STEPS_5X5 = 3'd6;

    localparam PE_weight_mode_t PHASE_ORDER [4] = '{A_MODE, B_MODE, C_MODE, D_MODE};

    // Final step index of a phase for the selected kernel (1 = 5x5).
    function automatic PE_state_t last_step(input logic kernel5);
        return kernel5 ? STEPS_5X5 : STEPS_3X3;
    endfunction

    // Weight mode driven during a phase; a 3x3 kernel only ever uses E_MODE.
    function automatic PE_weight_mode_t phase_mode(input logic kernel5, input logic [1:0] phase);
        return kernel5 ? PHASE_ORDER[phase] : E_MODE;
    endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Bundle between the layer controller / PE and the sequencing controller.
//   config + start/busy/done    : layer controller side
//   weight_req/weight_valid     : weight fetch handshake
//   act_valid/act_ready         : activation stream handshake
//   pe_fifo_full                : PE output FIFO back-pressure
//   state/weight_mode/finish/end_of_row/bit_mode : PE control outputs
// Modports: master = layer controller + PE side, slave = pe_seq_ctrl.
interface pe_seq_ctrl_if
    import diff_demo_pkg::*;
#(
    parameter int COL_W = 8,
    parameter int ROW_W = 8
);
    logic             start;
    logic             cfg_kernel;
    logic             cfg_bit_mode;
    logic [COL_W-1:0] cfg_cols;
    logic [ROW_W-1:0] cfg_rows;
    logic             weight_req;
    logic             weight_valid;
    logic             act_valid;
    logic             act_ready;
    logic             pe_fifo_full;
    PE_state_t        state;
    PE_weight_mode_t  weight_mode;
    logic             finish;
    logic             end_of_row;
    logic             bit_mode;
    logic             busy;
    logic             done;

    modport master (
        output start, cfg_kernel, cfg_bit_mode, cfg_cols, cfg_rows,
        output weight_valid, act_valid, pe_fifo_full,
        input  weight_req, act_ready, state, weight_mode,
        input  finish, end_of_row, bit_mode, busy, done
    );

    modport slave (
        input  start, cfg_kernel, cfg_bit_mode, cfg_cols, cfg_rows,
        input  weight_valid, act_valid, pe_fifo_full,
        output weight_req, act_ready, state, weight_mode,
        output finish, end_of_row, bit_mode, busy, done
    );
endinterface

// File: rtl/pe_tile_counter.sv
// Column/row tile counters for pe_seq_ctrl.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : zero both counters (new job)
//   advance_i     : one tile finished; column wraps to 0 and row increments
//   cols_i/rows_i : latched tiles-per-row and row count (both non-zero)
//   last_col_o    : current tile is the last of its row
//   last_tile_o   : current tile is the last tile of the job
module pe_tile_counter #(
    parameter int COL_W = 8,
    parameter int ROW_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [COL_W-1:0] cols_i,
    input  logic [ROW_W-1:0] rows_i,
    output logic             last_col_o,
    output logic             last_tile_o
);
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    assign last_col_o  = (col_q == cols_i - COL_W'(1));
    assign last_tile_o = last_col_o && (row_q == rows_i - ROW_W'(1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (last_col_o) begin
                col_d = '0;
                // Past the final row the value is irrelevant; clear_i resets it.
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencing controller for one convolution PE: fetches weights per phase,
// steps the PE state over the activation stream and pulses finish/end_of_row
// at tile/row boundaries, stalling on missing activations and a full PE FIFO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pe_seq_ctrl_if slave modport (config, handshakes, PE controls)
// Every output is a register except act_ready, a decode of the FSM state.
module pe_seq_ctrl
    import diff_demo_pkg::*;
#(
    parameter int COL_W = 8,
    parameter int ROW_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    pe_seq_ctrl_if.slave bus
);
    ctrl_state_t      ctrl_q, ctrl_d;
    logic             kernel_q, kernel_d;
    logic [COL_W-1:0] cols_q, cols_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic [1:0]       phase_q, phase_d;
    PE_state_t        state_q, state_d;
    PE_weight_mode_t  wmode_q, wmode_d;
    logic             finish_q, finish_d;
    logic             eor_q, eor_d;
    logic             wreq_q, wreq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bmode_q, bmode_d;

    logic cnt_clear;
    logic cnt_advance;
    logic last_col;
    logic last_tile;
    logic last_phase;

    pe_tile_counter #(
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_tile_counter (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (cnt_clear),
        .advance_i   (cnt_advance),
        .cols_i      (cols_q),
        .rows_i      (rows_q),
        .last_col_o  (last_col),
        .last_tile_o (last_tile)
    );

    assign last_phase = !kernel_q || (phase_q == 2'd3);

    always_comb begin
        ctrl_d      = ctrl_q;
        kernel_d    = kernel_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        phase_d     = phase_q;
        state_d     = PE_IDLE;
        wmode_d     = wmode_q;
        finish_d    = 1'b0;
        eor_d       = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bmode_d     = bmode_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;

        unique case (ctrl_q)
            CTRL_IDLE: begin
                if (bus.start) begin
                    kernel_d  = bus.cfg_kernel;
                    cols_d    = bus.cfg_cols;
                    rows_d    = bus.cfg_rows;
                    bmode_d   = bus.cfg_bit_mode;
                    phase_d   = 2'd0;
                    cnt_clear = 1'b1;
                    busy_d    = 1'b1;
                    // An empty job completes without touching the PE.
                    if (bus.cfg_cols == '0 || bus.cfg_rows == '0)
                        ctrl_d = CTRL_DONE;
                    else
                        ctrl_d = CTRL_REQ_W;
                end
            end
            CTRL_REQ_W: begin
                if (bus.weight_valid)
                    ctrl_d = CTRL_SETTLE;
            end
            CTRL_SETTLE: begin
                // Mode only changes on COMPUTE entry so the PE muxes stay
                // quiet while weights are being loaded.
                ctrl_d  = CTRL_COMPUTE;
                state_d = PE_state_t'(1);
                wmode_d = phase_mode(kernel_q, phase_q);
            end
            CTRL_COMPUTE: begin
                state_d = state_q;
                // act_ready is high throughout COMPUTE, so act_valid alone
                // marks a consumed activation.
                if (bus.act_valid) begin
                    if (state_q == last_step(kernel_q)) begin
                        state_d = PE_IDLE;
                        if (last_phase) begin
                            ctrl_d = CTRL_FIN;
                        end else begin
                            phase_d = phase_q + 2'd1;
                            ctrl_d  = CTRL_REQ_W;
                        end
                    end else begin
                        state_d = state_q + PE_state_t'(1);
                    end
                end
            end
            CTRL_FIN: begin
                if (!bus.pe_fifo_full) begin
                    finish_d    = 1'b1;
                    eor_d       = last_col;
                    cnt_advance = 1'b1;
                    phase_d     = 2'd0;
                    ctrl_d      = last_tile ? CTRL_DONE : CTRL_REQ_W;
                end
            end
            CTRL_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                ctrl_d = CTRL_IDLE;
            end
            default: begin
                ctrl_d = CTRL_IDLE;
            end
        endcase
    end

    // Registering the request from the next state keeps it aligned with REQ_W.
    assign wreq_d = (ctrl_d == CTRL_REQ_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= CTRL_IDLE;
            kernel_q <= 1'b0;
            cols_q   <= '0;
            rows_q   <= '0;
            phase_q  <= 2'd0;
            state_q  <= PE_IDLE;
            wmode_q  <= E_MODE;
            finish_q <= 1'b0;
            eor_q    <= 1'b0;
            wreq_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bmode_q  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            kernel_q <= kernel_d;
            cols_q   <= cols_d;
            rows_q   <= rows_d;
            phase_q  <= phase_d;
            state_q  <= state_d;
            wmode_q  <= wmode_d;
            finish_q <= finish_d;
            eor_q    <= eor_d;
            wreq_q   <= wreq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bmode_q  <= bmode_d;
        end
    end

    assign bus.act_ready   = (ctrl_q == CTRL_COMPUTE);
    assign bus.weight_req  = wreq_q;
    assign bus.state       = state_q;
    assign bus.weight_mode = wmode_q;
    assign bus.finish      = finish_q;
    assign bus.end_of_row  = eor_q;
    assign bus.bit_mode    = bmode_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_pe_seq_ctrl.sv
module tb_pe_seq_ctrl;
    import diff_demo_pkg::*;

    localparam int COL_W = 8;
    localparam int ROW_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_seq_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    pe_seq_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int   t;
        logic eor;
    } fin_exp_t;

    typedef struct {
        logic [2:0] st;
        logic [2:0] wm;
    } step_exp_t;

    fin_exp_t  fin_q[$];
    step_exp_t step_q[$];

    int errors = 0;
    int checks = 0;
    int t = 0;
    int exp_done_t = -1;
    int wreq_hs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic exp_fin(input int tt, input logic e);
        fin_exp_t f;
        f.t   = tt;
        f.eor = e;
        fin_q.push_back(f);
    endtask

    // Expected state / weight_mode for every COMPUTE step of one tile.
    task automatic push_tile(input logic k5);
        step_exp_t s;
        if (!k5) begin
            for (int i = 1; i <= 3; i++) begin
                s.st = 3'(i);
                s.wm = 3'd0;
                step_q.push_back(s);
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                for (int i = 1; i <= 6; i++) begin
                    s.st = 3'(i);
                    s.wm = 3'(p + 1);
                    step_q.push_back(s);
                end
            end
        end
    endtask

    // One clock; samples outputs 1 time unit after the edge and scores them.
    task automatic step();
        logic     consume;
        fin_exp_t f;
        consume = bus.act_ready && bus.act_valid;
        if (bus.weight_req && bus.weight_valid) wreq_hs++;
        @(posedge clk);
        #1;
        t++;
        if (consume && step_q.size() != 0) void'(step_q.pop_front());
        if (bus.act_ready) begin
            chk("step_expected", 32'(step_q.size() != 0), 32'd1);
            if (step_q.size() != 0) begin
                chk("state", 32'(bus.state), 32'(step_q[0].st));
                chk("weight_mode", 32'(bus.weight_mode), 32'(step_q[0].wm));
            end
        end else begin
            chk("state_idle", 32'(bus.state), 32'd0);
        end
        if (bus.finish) begin
            chk("finish_expected", 32'(fin_q.size() != 0), 32'd1);
            if (fin_q.size() != 0) begin
                f = fin_q.pop_front();
                $display("finish at t=%0d end_of_row=%0d", t, bus.end_of_row);
                chk("finish_time", t, f.t);
                chk("end_of_row", 32'(bus.end_of_row), 32'(f.eor));
            end
        end
        if (bus.done) begin
            $display("done at t=%0d", t);
            chk("done_time", t, exp_done_t);
            chk("busy_at_done", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic start_job(input logic k5, input logic bm, input int cols, input int rows);
        bus.start        = 1'b1;
        bus.cfg_kernel   = k5;
        bus.cfg_bit_mode = bm;
        bus.cfg_cols     = COL_W'(cols);
        bus.cfg_rows     = ROW_W'(rows);
        step();
        bus.start = 1'b0;
        t         = 0;
        wreq_hs   = 0;
        $display("start kernel5=%0d bit_mode=%0d cols=%0d rows=%0d", k5, bm, cols, rows);
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            step();
            n++;
        end
        chk("done_reached", 32'(bus.done), 32'd1);
        chk("finish_queue_empty", fin_q.size(), 0);
        chk("step_queue_empty", step_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_weight_mode"}, 32'(bus.weight_mode), 32'(E_MODE));
        chk({tag, "_finish"}, 32'(bus.finish), 32'd0);
        chk({tag, "_end_of_row"}, 32'(bus.end_of_row), 32'd0);
        chk({tag, "_weight_req"}, 32'(bus.weight_req), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_bit_mode"}, 32'(bus.bit_mode), 32'd0);
        chk({tag, "_act_ready"}, 32'(bus.act_ready), 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.cfg_kernel   = 1'b0;
        bus.cfg_bit_mode = 1'b0;
        bus.cfg_cols     = '0;
        bus.cfg_rows     = '0;
        bus.weight_valid = 1'b1;
        bus.act_valid    = 1'b1;
        bus.pe_fifo_full = 1'b0;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        // 3x3, two tiles in one row: finish at 6 and 12, done at 13.
        push_tile(1'b0);
        push_tile(1'b0);
        exp_fin(6, 1'b0);
        exp_fin(12, 1'b1);
        exp_done_t = 13;
        start_job(1'b0, 1'b1, 2, 1);
        chk("wreq_after_start", 32'(bus.weight_req), 32'd1);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("bit_mode", 32'(bus.bit_mode), 32'd1);
        run_to_done(40);
        chk("wreq_handshakes_3x3", wreq_hs, 2);
        step();

        // 5x5, one tile per row, two rows: finish every 33 cycles.
        push_tile(1'b1);
        push_tile(1'b1);
        exp_fin(33, 1'b1);
        exp_fin(66, 1'b1);
        exp_done_t = 67;
        start_job(1'b1, 1'b0, 1, 2);
        chk("bit_mode_low", 32'(bus.bit_mode), 32'd0);
        run_to_done(100);
        chk("wreq_handshakes_5x5", wreq_hs, 8);
        chk("weight_mode_held_after_job", 32'(bus.weight_mode), 32'(D_MODE));
        step();

        // act_valid low for 4 cycles mid-COMPUTE: tile 4 cycles longer.
        push_tile(1'b0);
        exp_fin(10, 1'b1);
        exp_done_t = 11;
        start_job(1'b0, 1'b0, 1, 1);
        repeat (3) step();
        chk("state_before_stall", 32'(bus.state), 32'd2);
        bus.act_valid = 1'b0;
        repeat (4) step();
        bus.act_valid = 1'b1;
        run_to_done(20);
        step();

        // PE FIFO full for the first 10 FIN cycles: one finish after release.
        push_tile(1'b0);
        exp_fin(16, 1'b1);
        exp_done_t = 17;
        start_job(1'b0, 1'b0, 1, 1);
        repeat (5) step();
        bus.pe_fifo_full = 1'b1;
        repeat (10) step();
        bus.pe_fifo_full = 1'b0;
        run_to_done(20);
        step();

        // Empty job: busy for one cycle, done pulse, a start while busy is dropped.
        exp_done_t = 1;
        start_job(1'b0, 1'b0, 0, 3);
        chk("cols0_busy", 32'(bus.busy), 32'd1);
        chk("cols0_wreq", 32'(bus.weight_req), 32'd0);
        bus.start    = 1'b1;
        bus.cfg_cols = COL_W'(1);
        step();
        bus.start = 1'b0;
        chk("cols0_done", 32'(bus.done), 32'd1);
        step();
        chk("ignored_start_busy", 32'(bus.busy), 32'd0);
        chk("ignored_start_wreq", 32'(bus.weight_req), 32'd0);
        step();
        chk("ignored_start_wreq_late", 32'(bus.weight_req), 32'd0);

        // Reset in the middle of a 5x5 tile, then a clean 2x2-tile job.
        push_tile(1'b1);
        exp_fin(33, 1'b1);
        exp_done_t = 34;
        start_job(1'b1, 1'b1, 1, 1);
        repeat (11) step();
        chk("compute_before_reset", 32'(bus.act_ready), 32'd1);
        rst = 1'b1;
        step();
        check_reset_vals("midrun_reset");
        rst = 1'b0;
        step_q.delete();
        fin_q.delete();
        step();
        for (int i = 0; i < 4; i++) push_tile(1'b0);
        exp_fin(6, 1'b0);
        exp_fin(12, 1'b1);
        exp_fin(18, 1'b0);
        exp_fin(24, 1'b1);
        exp_done_t = 25;
        start_job(1'b0, 1'b0, 2, 2);
        run_to_done(60);
        chk("wreq_handshakes_after_reset", wreq_hs, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_seq_ctrl.md
# pe_seq_ctrl

Sequencing controller for one convolution PE. Fetches kernel weights, steps the PE's `state`/`weight_mode` inputs over an activation stream, and issues `finish`/`end_of_row` at tile and row boundaries. Stalls on missing activations and on a full PE output FIFO. Sits between the layer controller (config plus start/done) and a single PE instance.

## Interface

**Parameters**

- `COL_W`, default 8: width of the tiles-per-row count.
- `ROW_W`, default 8: width of the row count.

**Ports** (name, direction, width, meaning)

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle launch pulse. Ignored while `busy`.
- `cfg_kernel` in 1: 0 = 3x3 kernel, 1 = 5x5 kernel. Sampled on `start`.
- `cfg_bit_mode` in 1: multiplier precision. Sampled on `start`, driven on `bit_mode`.
- `cfg_cols` in `COL_W`: tiles per row. Sampled on `start`.
- `cfg_rows` in `ROW_W`: rows. Sampled on `start`.
- `weight_req` out 1: request the next weight word.
- `weight_valid` in 1: the weight word is present on the PE `weight_i` this cycle.
- `act_valid` in 1: activation byte valid.
- `act_ready` out 1: PE consumes the activation this cycle.
- `pe_fifo_full` in 1: PE output FIFO full.
- `state` out `PE_state_t`: PE step index, IDLE = 0.
- `weight_mode` out `PE_weight_mode_t`: current kernel phase.
- `finish` out 1: tile-complete pulse to the PE.
- `end_of_row` out 1: last tile of a row. Valid only with `finish`.
- `bit_mode` out 1: registered copy of `cfg_bit_mode`.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.

## Operation

**Controller states**
- IDLE, REQ_W, SETTLE, COMPUTE, FIN, DONE.

**Phase schedule per tile**
- 3x3: a single phase, E_MODE, with `state` stepping 1..3.
- 5x5: four phases A_MODE, B_MODE, C_MODE, D_MODE, each with `state` stepping 1..6.
- Each phase reloads weights.

**Transitions**
- IDLE → REQ_W on `start`. Configuration is latched and `busy` is set.
- If `cfg_cols == 0` or `cfg_rows == 0`, IDLE → DONE instead, with no PE activity.
- REQ_W: hold `weight_req` until `weight_valid`, then go to SETTLE.
- SETTLE: one cycle to cover the PE's weight register, then go to COMPUTE with `state = 1`.
- COMPUTE: `act_ready = 1`. `state` advances only on `act_valid && act_ready`.
  - After the final step of a non-last phase: next phase, then REQ_W.
  - After the final step of the last phase: FIN.
- FIN: `finish = 1` only when `!pe_fifo_full`. While full, stay in FIN with `finish = 0`.
  - `end_of_row = 1` with `finish` when the column counter equals `cfg_cols - 1`.
  - After `finish`: if the last tile of the last row, go to DONE. Otherwise go to REQ_W, with the column counter wrapping to 0 and the row counter incrementing at the end of each row.
- DONE: `done = 1` for one cycle, `busy` clears, go to IDLE.

**Output rules**
- `state` is IDLE in every controller state except COMPUTE.
- `weight_mode` holds its value outside COMPUTE. The PE multiplexers must not toggle.
- `start` while `busy` is dropped. No queuing.
- `rst` at any cycle returns to IDLE next edge. Counters are cleared and all outputs take reset values.

**Reset values**
- All outputs 0. `state` = IDLE. `weight_mode` = E_MODE.

## Timing

- All outputs are registered. No combinational path from input to output except `act_ready`, which equals `(ctrl == COMPUTE)`.
- `start` to first `weight_req`: 1 cycle.
- `weight_valid` to first COMPUTE step: 2 cycles (SETTLE, then COMPUTE).
- 3x3 tile with no stalls, from REQ_W entry: 1 + 1 + 3 + 1 = 6 cycles.
- 5x5 tile with no stalls: 4 × (1 + 1 + 6) + 1 = 33 cycles.
- `done` comes exactly 1 cycle after the last `finish`.
- `pe_fifo_full` deasserting in FIN gives `finish` on that same cycle's next edge.
- `act_valid` low in COMPUTE freezes `state`. No bubble is inserted on resumption.

## Structure

- Extend `diff_demo_pkg` with:
  - `ctrl_state_t` enum.
  - `STEPS_3X3 = 3` and `STEPS_5X5 = 6`.
  - Phase-order constant A, B, C, D.
- Reuse the existing `PE_state_t` and `PE_weight_mode_t`.
- One sub-module, `pe_tile_counter`: column/row counters with wrap, `last_col`, and `last_tile` flags.

## Test plan

- 3x3, `cols = 2`, `rows = 1`, all valids high → `state` goes 1, 2, 3 per tile, two `finish` pulses at cycles 6 and 12 after `start`, `end_of_row` on the second, `done` 1 cycle later.
- 5x5, `cols = 1`, `rows = 2` → `weight_mode` sequence A, B, C, D per tile, 8 `weight_req` handshakes, `finish` every 33 cycles, `end_of_row` high on both `finish` pulses.
- `act_valid` low for 4 cycles mid-COMPUTE → `state` held, tile lengthened by exactly 4 cycles.
- `pe_fifo_full` high for 10 cycles entering FIN → no `finish` for 10 cycles, a single `finish` after release.
- `cfg_cols = 0` → `busy` high 1 cycle, `done` pulse, no `weight_req`. A `start` during `busy` is ignored.
- `rst` asserted mid-COMPUTE of a 5x5 tile → next cycle all outputs at reset values. A new `start` runs cleanly from tile 0.
